// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared constants and types for the adder_sched slice
package adder_pkg;
   localparam int DATA_W   = 16;
   localparam int NREQ_DEF = 4;
   localparam int ID_W_DEF = 2;

   typedef logic [DATA_W-1:0] word_t;

   localparam word_t SAT_POS = 16'h7FFF;
   localparam word_t SAT_NEG = 16'h8000;
endpackage

// File: rtl/adder_sched_rr_arbiter.sv
// rtl/adder_sched_rr_arbiter.sv - round-robin arbiter with rotating priority pointer
module rr_arbiter #(
   parameter int NREQ = 4,
   parameter int ID_W = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [NREQ-1:0] req,
   input  logic            hold,
   output logic [NREQ-1:0] gnt,
   output logic [ID_W-1:0] win_id,
   output logic            win_vld
);
   logic [ID_W-1:0] ptr;
   logic [ID_W-1:0] idx;

   always_comb begin
      gnt     = '0;
      win_id  = '0;
      win_vld = 1'b0;
      idx     = '0;
      for (int k = 0; k < NREQ; k++) begin
         idx = ID_W'((int'(ptr) + k) % NREQ);
         if (!win_vld && !hold && req[idx]) begin
            win_vld  = 1'b1;
            win_id   = idx;
         end
      end
      if (win_vld) gnt[win_id] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= '0;
      end else if (win_vld) begin
         ptr <= (win_id == ID_W'(NREQ-1)) ? '0 : win_id + 1'b1;
      end
   end
endmodule

// File: rtl/cla_16.sv
// rtl/cla_16.sv - 16-bit carry-lookahead adder, four 4-bit lookahead groups
module cla_16 (
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic        cin,
   output logic [15:0] sum,
   output logic        cout
);
   logic [15:0] g;
   logic [15:0] p;
   logic [15:0] c;
   logic [3:0]  gg;
   logic [3:0]  gp;
   logic        gcarry;
   logic        rc;

   always_comb begin
      g      = a & b;
      p      = a ^ b;
      c      = '0;
      gg     = '0;
      gp     = '0;
      gcarry = cin;
      rc     = 1'b0;
      for (int j = 0; j < 4; j++) begin
         gp[j] = &p[4*j +: 4];
         gg[j] = g[4*j+3]
               | (p[4*j+3] & g[4*j+2])
               | (p[4*j+3] & p[4*j+2] & g[4*j+1])
               | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
         // bit carries inside a group come from the group carry-in
         rc = gcarry;
         for (int k = 0; k < 4; k++) begin
            c[4*j+k] = rc;
            rc       = g[4*j+k] | (p[4*j+k] & rc);
         end
         gcarry = gg[j] | (gp[j] & gcarry);
      end
      sum  = p ^ c;
      cout = gcarry;
   end
endmodule

// File: rtl/adder_sched.sv
// rtl/adder_sched.sv - round-robin scheduler sharing one cla_16 across NREQ clients, 2-stage pipe
// Optional signed saturation of rsp_sum when ADDER_SAT_EN is defined.
module adder_sched
   import adder_pkg::*;
#(
   parameter int NREQ = NREQ_DEF,
   parameter int ID_W = ID_W_DEF
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NREQ-1:0]        req,
   input  logic [DATA_W*NREQ-1:0] a_flat,
   input  logic [DATA_W*NREQ-1:0] b_flat,
   input  logic [NREQ-1:0]        cin_v,
   input  logic                   hold,
   output logic [NREQ-1:0]        gnt,
   output logic                   rsp_vld,
   output logic [ID_W-1:0]        rsp_id,
   output logic [DATA_W-1:0]      rsp_sum,
   output logic                   rsp_cout,
   output logic                   rsp_ovfl
);
   logic [ID_W-1:0] win_id;
   logic            win_vld;

   word_t           s1_a;
   word_t           s1_b;
   logic            s1_cin;
   logic [ID_W-1:0] s1_id;
   logic            s1_v;

   word_t           add_sum;
   logic            add_cout;
   logic            add_ovfl;
   word_t           sum_out;

   rr_arbiter #(.NREQ(NREQ), .ID_W(ID_W)) u_arb (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req),
      .hold    (hold),
      .gnt     (gnt),
      .win_id  (win_id),
      .win_vld (win_vld)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_a   <= '0;
         s1_b   <= '0;
         s1_cin <= 1'b0;
         s1_id  <= '0;
         s1_v   <= 1'b0;
      end else begin
         s1_v <= win_vld;
         if (win_vld) begin
            s1_a   <= a_flat[int'(win_id)*DATA_W +: DATA_W];
            s1_b   <= b_flat[int'(win_id)*DATA_W +: DATA_W];
            s1_cin <= cin_v[win_id];
            s1_id  <= win_id;
         end
      end
   end

   cla_16 u_cla (
      .a    (s1_a),
      .b    (s1_b),
      .cin  (s1_cin),
      .sum  (add_sum),
      .cout (add_cout)
   );

   assign add_ovfl = (s1_a[DATA_W-1] == s1_b[DATA_W-1]) && (add_sum[DATA_W-1] != s1_a[DATA_W-1]);

`ifdef ADDER_SAT_EN
   // clamp toward the sign of the operands; flags stay raw
   assign sum_out = !add_ovfl ? add_sum : (s1_a[DATA_W-1] ? SAT_NEG : SAT_POS);
`else
   assign sum_out = add_sum;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_vld  <= 1'b0;
         rsp_id   <= '0;
         rsp_sum  <= '0;
         rsp_cout <= 1'b0;
         rsp_ovfl <= 1'b0;
      end else begin
         rsp_vld <= s1_v;
         if (s1_v) begin
            rsp_id   <= s1_id;
            rsp_sum  <= sum_out;
            rsp_cout <= add_cout;
            rsp_ovfl <= add_ovfl;
         end
      end
   end
endmodule

// File: tb/tb_adder_sched.sv
// tb/tb_adder_sched.sv - scoreboard bench for adder_sched, directed vectors then random clients
module tb_adder_sched;
   import adder_pkg::*;

   localparam int N = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [N-1:0]  req;
   logic [16*N-1:0] a_flat;
   logic [16*N-1:0] b_flat;
   logic [N-1:0]  cin_v;
   logic          hold;
   logic [N-1:0]  gnt;
   logic          rsp_vld;
   logic [1:0]    rsp_id;
   logic [15:0]   rsp_sum;
   logic          rsp_cout;
   logic          rsp_ovfl;

   adder_sched #(.NREQ(N), .ID_W(2)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req      (req),
      .a_flat   (a_flat),
      .b_flat   (b_flat),
      .cin_v    (cin_v),
      .hold     (hold),
      .gnt      (gnt),
      .rsp_vld  (rsp_vld),
      .rsp_id   (rsp_id),
      .rsp_sum  (rsp_sum),
      .rsp_cout (rsp_cout),
      .rsp_ovfl (rsp_ovfl)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  id;
      logic [15:0] sum;
      logic        cout;
      logic        ovfl;
      int          due;
   } exp_t;

   exp_t sbq[$];
   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;
   int   mptr     = 0;
   int   m_win    = -1;

   always @(posedge clk) cyc <= cyc + 1;

   // checker: reference grant and expected result for each issued op
   logic [N-1:0] exp_g;
   logic [15:0]  ma, mb;
   logic         mc;
   logic [16:0]  u;
   int           s;
   int           ci;
   exp_t         e;

   always @(negedge clk) begin
      if (!rst_n) begin
         sbq.delete();
         mptr  = 0;
         m_win = -1;
         checks++;
         if (gnt !== '0 || rsp_vld !== 1'b0 || rsp_id !== 2'd0 || rsp_sum !== 16'h0 ||
             rsp_cout !== 1'b0 || rsp_ovfl !== 1'b0) begin
            failures++;
            $display("FAIL reset_state gnt=%b vld=%b id=%0d sum=%h cout=%b ovfl=%b required all zero",
                     gnt, rsp_vld, rsp_id, rsp_sum, rsp_cout, rsp_ovfl);
         end
      end else begin
         m_win = -1;
         if (!hold) begin
            for (int k = 0; k < N; k++) begin
               ci = (mptr + k) % N;
               if (m_win < 0 && req[ci]) m_win = ci;
            end
         end
         exp_g = '0;
         if (m_win >= 0) exp_g[m_win] = 1'b1;
         checks++;
         if (gnt !== exp_g) begin
            failures++;
            $display("FAIL gnt cyc=%0d got=%b exp=%b", cyc, gnt, exp_g);
         end
         if (m_win >= 0) begin
            ma = a_flat[16*m_win +: 16];
            mb = b_flat[16*m_win +: 16];
            mc = cin_v[m_win];
            u  = {1'b0, ma} + {1'b0, mb} + {16'b0, mc};
            s  = int'($signed(ma)) + int'($signed(mb)) + int'(mc);
            e.id   = 2'(m_win);
            e.cout = u[16];
            e.ovfl = (s > 32767) || (s < -32768);
            e.sum  = u[15:0];
`ifdef ADDER_SAT_EN
            if (s > 32767) e.sum = 16'h7FFF;
            else if (s < -32768) e.sum = 16'h8000;
`endif
            e.due = cyc + 2;
            sbq.push_back(e);
            mptr = (m_win + 1) % N;
         end
      end
   end

   // monitor: pops on every rsp_vld, also checks held outputs when idle
   exp_t got_e;
   exp_t last;

   always @(negedge clk) begin
      if (!rst_n) begin
         last.id = 2'd0; last.sum = 16'h0; last.cout = 1'b0; last.ovfl = 1'b0; last.due = 0;
      end else begin
         if (sbq.size() > 0 && sbq[0].due < cyc) begin
            checks++;
            failures++;
            $display("FAIL missing_rsp cyc=%0d got=none exp_id=%0d due=%0d", cyc, sbq[0].id, sbq[0].due);
            void'(sbq.pop_front());
         end
         checks++;
         if (rsp_vld) begin
            if (sbq.size() == 0 || sbq[0].due != cyc) begin
               failures++;
               $display("FAIL unexpected_rsp cyc=%0d got_id=%0d sum=%h exp=no response", cyc, rsp_id, rsp_sum);
            end else begin
               got_e = sbq.pop_front();
               if (rsp_id !== got_e.id || rsp_sum !== got_e.sum || rsp_cout !== got_e.cout ||
                   rsp_ovfl !== got_e.ovfl) begin
                  failures++;
                  $display("FAIL rsp cyc=%0d got id=%0d sum=%h cout=%b ovfl=%b exp id=%0d sum=%h cout=%b ovfl=%b",
                           cyc, rsp_id, rsp_sum, rsp_cout, rsp_ovfl,
                           got_e.id, got_e.sum, got_e.cout, got_e.ovfl);
               end
               last = got_e;
            end
         end else if (rsp_id !== last.id || rsp_sum !== last.sum || rsp_cout !== last.cout ||
                      rsp_ovfl !== last.ovfl) begin
            failures++;
            $display("FAIL rsp_hold cyc=%0d got id=%0d sum=%h cout=%b ovfl=%b exp id=%0d sum=%h cout=%b ovfl=%b",
                     cyc, rsp_id, rsp_sum, rsp_cout, rsp_ovfl, last.id, last.sum, last.cout, last.ovfl);
         end
      end
   end

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) begin
         req  = '0;
         hold = 1'b0;
         @(posedge clk); #1;
      end
   endtask

   task automatic op1(input int i, input logic [15:0] a, input logic [15:0] b, input logic c);
      req = '0;
      req[i] = 1'b1;
      a_flat[16*i +: 16] = a;
      b_flat[16*i +: 16] = b;
      cin_v[i] = c;
      hold = 1'b0;
      @(posedge clk); #1;
      req = '0;
   endtask

   task automatic all_req(input int n, input logic h);
      for (int k = 0; k < n; k++) begin
         for (int i = 0; i < N; i++) begin
            a_flat[16*i +: 16] = 16'($urandom);
            b_flat[16*i +: 16] = 16'($urandom);
            cin_v[i] = 1'($urandom);
         end
         req  = '1;
         hold = h;
         @(posedge clk); #1;
      end
      req  = '0;
      hold = 1'b0;
   endtask

   function automatic logic [15:0] rval();
      case ($urandom_range(0, 7))
         0: return 16'h0000;
         1: return 16'hFFFF;
         2: return 16'h7FFF;
         3: return 16'h8000;
         default: return 16'($urandom);
      endcase
   endfunction

   logic         pend [N];
   logic [15:0]  pa [N];
   logic [15:0]  pb [N];
   logic         pc [N];

   initial begin
      rst_n  = 1'b0;
      req    = '0;
      hold   = 1'b0;
      a_flat = '0;
      b_flat = '0;
      cin_v  = '0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // fairness from reset: grants 1,2,4,8,1,2,4,8
      all_req(8, 1'b0);
      idle(3);

      op1(2, 16'h1234, 16'h0001, 1'b0);
      op1(1, 16'hFFFF, 16'h0001, 1'b0);
      op1(3, 16'h7FFF, 16'h0001, 1'b0);
      op1(0, 16'h8000, 16'h8000, 1'b0);
      op1(2, 16'h0005, ~16'h0007, 1'b1);
      op1(1, 16'h7FFF, 16'h0000, 1'b1);
      idle(3);

      // hold blocks grants while an op drains
      all_req(1, 1'b0);
      all_req(3, 1'b1);
      all_req(4, 1'b0);
      idle(3);

      // reset with two ops in flight
      all_req(2, 1'b0);
      rst_n = 1'b0;
      req   = '0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      idle(2);
      all_req(2, 1'b0);
      idle(3);

      // random clients that hold req until granted
      for (int i = 0; i < N; i++) pend[i] = 1'b0;
      for (int t = 0; t < 400; t++) begin
         for (int i = 0; i < N; i++) begin
            if (!pend[i] && $urandom_range(0, 1) == 1) begin
               pend[i] = 1'b1;
               pa[i] = rval();
               pb[i] = rval();
               pc[i] = 1'($urandom);
            end
            req[i] = pend[i];
            a_flat[16*i +: 16] = pa[i];
            b_flat[16*i +: 16] = pb[i];
            cin_v[i] = pc[i];
         end
         hold = ($urandom_range(0, 7) == 0);
         @(posedge clk); #1;
         if (m_win >= 0) pend[m_win] = 1'b0;
      end
      idle(5);

      checks++;
      if (sbq.size() != 0) begin
         failures++;
         $display("FAIL drain got=%0d pending exp=0", sbq.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
